// File: rtl/imem_loader.sv
// Instruction-memory program loader: parses a length-prefixed big-endian byte
// frame, writes consecutive 32-bit words and verifies a trailing XOR checksum.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_written
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept;
  logic [15:0] len_full;

  assign accept   = rx_valid & rx_ready_q;
  assign len_full = {len_q[15:8], rx_data};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    addr_d       = addr_q;
    words_d      = words_q;
    asm_d        = asm_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        // ERR swallows bytes silently; only a fresh start leaves it.
        if (start) begin
          state_d    = S_LEN_HI;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          words_d    = '0;
          addr_d     = '0;
          csum_d     = '0;
          byte_cnt_d = '0;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else if ({16'd0, len_full} > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          asm_d      = {asm_q[23:0], rx_data};
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Write uses the pre-increment address so addr/data line up with we.
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = {asm_q[23:0], rx_data};
            imem_addr_d  = addr_q;
            addr_d       = addr_q + ADDR_W'(1);
            words_d      = words_q + 16'd1;
            if (words_q + 16'd1 == len_q) begin
              state_d = S_CHECK;
            end
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (rx_data == csum_q) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Ready is registered and derived from the next state, so it is high in every
  // non-IDLE state and first rises the cycle after start is taken.
  always_comb begin
    rx_ready_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      addr_q       <= '0;
      words_q      <= '0;
      asm_q        <= '0;
      byte_cnt_q   <= '0;
      csum_q       <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      asm_q        <= asm_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready      = rx_ready_q;
  assign imem_we       = imem_we_q;
  assign imem_addr     = imem_addr_q;
  assign imem_wdata    = imem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_q;

endmodule
